// File: rtl/store_buffer.sv
// Store buffer: forms big-endian byte lanes and byte enables for SB/SH/SW, queues them in a
// DEPTH-entry FIFO and drains to the data cache by req/ack. Optional macro: STORE_MISALIGN_TRAP_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  output logic        st_misalign,
  output logic        dm_wr_req,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byte_en,
  input  logic        dm_wr_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        sb_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [29:0]   mem_addr  [DEPTH];
  logic [31:0]   mem_wdata [DEPTH];
  logic [3:0]    mem_be    [DEPTH];

  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [AW-1:0] head_inc;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [29:0]   dm_addr_reg;
  logic [31:0]   dm_wdata_reg;
  logic [3:0]    dm_be_reg;

  logic [31:0]   new_wdata;
  logic [3:0]    new_be;
  logic          f3_ok;
  logic          misaligned;
  logic          accept;
  logic          push;
  logic          pop;
  logic          load_mem;
  logic          load_new;
  logic [DEPTH-1:0] hit_vec;
  logic          ld_addr_unused;

  assign sb_empty   = (count_reg == '0);
  assign st_ready   = (count_reg != FULL_COUNT);
  assign dm_wr_req  = !sb_empty;
  assign dm_addr    = {dm_addr_reg, 2'b00};
  assign dm_wdata   = dm_wdata_reg;
  assign dm_byte_en = dm_be_reg;
  assign ld_addr_unused = ^ld_addr[1:0];

  always_comb begin
    f3_ok      = 1'b1;
    misaligned = 1'b0;
    new_wdata  = st_data;
    new_be     = 4'b1111;
    case (st_funct3)
      3'b000: begin
        new_wdata = {4{st_data[7:0]}};
        new_be    = 4'b1000 >> st_addr[1:0];
      end
      3'b001: begin
        new_wdata = {2{st_data[15:0]}};
        new_be    = st_addr[1] ? 4'b0011 : 4'b1100;
      end
      3'b010: ;
      default: f3_ok = 1'b0;
    endcase
`ifdef STORE_MISALIGN_TRAP_EN
    misaligned = ((st_funct3 == 3'b001) && st_addr[0]) ||
                 ((st_funct3 == 3'b010) && (st_addr[1:0] != 2'b00));
`endif
  end

  assign accept   = st_valid && st_ready;
  assign push     = accept && f3_ok && !misaligned;
  assign pop      = dm_wr_req && dm_wr_ack;
  assign head_inc = head_reg + AW'(1);

  // The head registers track the oldest entry; when the only entry pops while a new one
  // arrives, the new one is still in flight to the array and must be taken directly.
  always_comb begin
    load_mem = 1'b0;
    load_new = 1'b0;
    if (pop) begin
      if (count_reg > CW'(1)) load_mem = 1'b1;
      else if (push)          load_new = 1'b1;
    end else if (sb_empty && push) begin
      load_new = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail_reg]  <= st_addr[31:2];
      mem_wdata[tail_reg] <= new_wdata;
      mem_be[tail_reg]    <= new_be;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      dm_addr_reg  <= '0;
      dm_wdata_reg <= '0;
      dm_be_reg    <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + AW'(1);
      if (pop)  head_reg <= head_inc;
      count_reg <= count_next;
      if (load_mem) begin
        dm_addr_reg  <= mem_addr[head_inc];
        dm_wdata_reg <= mem_wdata[head_inc];
        dm_be_reg    <= mem_be[head_inc];
      end else if (load_new) begin
        dm_addr_reg  <= st_addr[31:2];
        dm_wdata_reg <= new_wdata;
        dm_be_reg    <= new_be;
      end
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign_reg;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) misalign_reg <= 1'b0;
    else       misalign_reg <= accept && misaligned;
  end
  assign st_misalign = misalign_reg;
`else
  assign st_misalign = 1'b0;
`endif

  // A slot is live when its distance from head is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      logic [AW-1:0] rel;
      assign rel         = AW'(gi) - head_reg;
      assign hit_vec[gi] = ({1'b0, rel} < count_reg) && (mem_addr[gi] == ld_addr[31:2]);
    end
  endgenerate

  assign ld_hit = |hit_vec;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected entries are queued on acceptance and
// compared against dm_* on every req/ack pop. Honours STORE_MISALIGN_TRAP_EN.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_funct3 = '0;
  logic        st_misalign;
  logic        dm_wr_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byte_en;
  logic        dm_wr_ack = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic        sb_empty;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_funct3(st_funct3), .st_misalign(st_misalign),
    .dm_wr_req(dm_wr_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byte_en(dm_byte_en),
    .dm_wr_ack(dm_wr_ack), .ld_addr(ld_addr), .ld_hit(ld_hit), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [67:0] exp_q[$];

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] model_entry(input logic [31:0] a, input logic [31:0] d,
                                              input logic [2:0] f3);
    logic [31:0] w;
    logic [3:0]  be;
    w  = d;
    be = 4'b1111;
    if (f3 == 3'b000) begin
      w = {d[7:0], d[7:0], d[7:0], d[7:0]};
      case (a[1:0])
        2'd0: be = 4'b1000;
        2'd1: be = 4'b0100;
        2'd2: be = 4'b0010;
        default: be = 4'b0001;
      endcase
    end else if (f3 == 3'b001) begin
      w  = {d[15:0], d[15:0]};
      be = (a[1:0] < 2'd2) ? 4'b1100 : 4'b0011;
    end
    return {a[31:2], 2'b00, w, be};
  endfunction

  function automatic bit model_enq(input logic [31:0] a, input logic [2:0] f3);
    if (f3 > 3'b010) return 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    if (f3 == 3'b001 && a[0]) return 1'b0;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b0;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (nrst && st_valid && st_ready && model_enq(st_addr, st_funct3))
      exp_q.push_back(model_entry(st_addr, st_data, st_funct3));
  end

  always @(negedge clk) begin
    if (nrst && dm_wr_req && dm_wr_ack) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 68'(dm_wr_req), 68'd0);
      end else begin
        logic [67:0] e;
        e = exp_q.pop_front();
        $display("pop addr=%h wdata=%h be=%b", dm_addr, dm_wdata, dm_byte_en);
        check("pop_entry", {dm_addr, dm_wdata, dm_byte_en}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    bit acc;
    acc = 1'b0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (st_ready) begin
        acc = 1'b1;
        tick();
      end
    end
    if (!acc) check("offer_timeout", 68'd0, 68'd1);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && !sb_empty; i++) tick();
    check("drain_done", 68'(sb_empty), 68'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 68'(st_ready), 68'd1);
    check("rst_req", 68'(dm_wr_req), 68'd0);
    check("rst_dm", {dm_addr, dm_wdata, dm_byte_en}, 68'd0);
    check("rst_empty", 68'(sb_empty), 68'd1);
    check("rst_mis", 68'(st_misalign), 68'd0);
    @(negedge clk) nrst = 1'b1;
    tick();

    // Single SB, held then acked
    offer(32'h103, 32'h000000A5, 3'b000);
    st_valid = 1'b0;
    check("t1_req", 68'(dm_wr_req), 68'd1);
    check("t1_entry", {dm_addr, dm_wdata, dm_byte_en}, {32'h100, 32'hA5A5A5A5, 4'b0001});
    ld_addr = 32'h103; #1;
    check("t1_hit", 68'(ld_hit), 68'd1);
    ld_addr = 32'h104; #1;
    check("t1_nohit", 68'(ld_hit), 68'd0);
    dm_wr_ack = 1'b1;
    tick();
    dm_wr_ack = 1'b0;
    check("t1_empty", 68'(sb_empty), 68'd1);
    check("t1_req_low", 68'(dm_wr_req), 68'd0);
    check("t1_hold", 68'(dm_wdata), 68'h0A5A5A5A5);

    // Back-to-back SH/SW with ack held high: one per cycle
    dm_wr_ack = 1'b1;
    offer(32'h202, 32'h00001234, 3'b001);
    offer(32'h300, 32'hDEADBEEF, 3'b010);
    st_valid = 1'b0;
    tick();
    check("t2_drained", 68'(sb_empty), 68'd1);
    check("t2_q", 68'(exp_q.size()), 68'd0);
    dm_wr_ack = 1'b0;

    // Fill to DEPTH, fifth store blocked, one ack frees a slot, wrap to slot 0
    for (int i = 0; i < 4; i++) offer(32'h600 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 3'b010);
    check("t3_full_ready", 68'(st_ready), 68'd0);
    check("t3_not_empty", 68'(sb_empty), 68'd0);
    st_addr = 32'h610; st_data = 32'h55; st_funct3 = 3'b010;
    tick();
    check("t3_blocked", 68'(st_ready), 68'd0);
    check("t3_q4", 68'(exp_q.size()), 68'd4);
    ld_addr = 32'h60B; #1;
    check("t3_hit", 68'(ld_hit), 68'd1);
    ld_addr = 32'h610; #1;
    check("t3_nohit_hi", 68'(ld_hit), 68'd0);
    ld_addr = 32'h5FC; #1;
    check("t3_nohit_lo", 68'(ld_hit), 68'd0);
    dm_wr_ack = 1'b1;
    tick();
    dm_wr_ack = 1'b0;
    check("t3_ready_after_ack", 68'(st_ready), 68'd1);
    tick();
    st_valid = 1'b0;
    check("t3_refull", 68'(st_ready), 68'd0);
    check("t3_head", 68'(dm_addr), 68'h604);
    dm_wr_ack = 1'b1;
    wait_empty(20);
    dm_wr_ack = 1'b0;

    // Lane mapping table, drained with ack high
    dm_wr_ack = 1'b1;
    for (int k = 0; k < 4; k++) offer(32'h700 + 32'(k), 32'hC0 + 32'(k), 3'b000);
    offer(32'h200, 32'h0000BEEF, 3'b001);
    offer(32'h203, 32'h0000CAFE, 3'b001);
    offer(32'h710, 32'h0, 3'b011);
    st_valid = 1'b0;
    wait_empty(20);
    dm_wr_ack = 1'b0;
    tick();
    offer(32'h720, 32'h1, 3'b111);
    st_valid = 1'b0;
    check("t4_invalid_drop", 68'(sb_empty), 68'd1);
    check("t4_invalid_nomis", 68'(st_misalign), 68'd0);

    // Misaligned SW
    offer(32'h501, 32'hCAFEF00D, 3'b010);
    st_valid = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    check("t5_mis_pulse", 68'(st_misalign), 68'd1);
    check("t5_not_enq", 68'(sb_empty), 68'd1);
    tick();
    check("t5_mis_off", 68'(st_misalign), 68'd0);
`else
    check("t5_mis_zero", 68'(st_misalign), 68'd0);
    check("t5_entry", {32'h0, dm_addr, dm_byte_en}, {32'h0, 32'h500, 4'hF});
    dm_wr_ack = 1'b1;
    wait_empty(10);
    dm_wr_ack = 1'b0;
`endif

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) offer(32'h800 + 32'(4 * i), 32'(i), 3'b010);
    st_valid = 1'b0;
    check("t6_req", 68'(dm_wr_req), 68'd1);
    #2 nrst = 1'b0;
    #1;
    check("t6_req_drop", 68'(dm_wr_req), 68'd0);
    check("t6_empty", 68'(sb_empty), 68'd1);
    check("t6_dm_zero", {dm_addr, dm_wdata, dm_byte_en}, 68'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    dm_wr_ack = 1'b1;
    repeat (5) tick();
    dm_wr_ack = 1'b0;
    check("t6_no_stale", 68'(dm_wr_req), 68'd0);
    check("final_q", 68'(exp_q.size()), 68'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
